// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_NONE   = 0;

  // One in-flight instruction tracked after ID.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  is_load;
  } hz_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one ID source operand against every tracked in-flight writer.
// Reports the youngest matching stage, whether a load there is still too
// young to forward, and whether the only producer is the WB stage.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_STG = 2,
  parameter int SEL_W        = 2
) (
  input  logic [REG_ADDR_W-1:0]  i_src,
  input  logic                   i_used,
  input  hz_entry_t [DEPTH-1:0]  i_entry,
  output logic [SEL_W-1:0]       o_idx,
  output logic                   o_hit,
  output logic                   o_load_young,
  output logic                   o_wb_only
);

  logic [DEPTH-1:0] w_match;

  // Raw per-stage match; x0 is hard-wired zero and never creates a hazard.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_match[k] = i_used && (i_src != '0) && i_entry[k].valid &&
                   i_entry[k].wen && (i_entry[k].rd == i_src);
    end
  end

  // Scan oldest to youngest so the lowest matching stage is left in o_idx.
  always_comb begin
    o_idx        = '0;
    o_hit        = 1'b0;
    o_load_young = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_idx = SEL_W'(k);
        o_hit = 1'b1;
        if (i_entry[k].is_load && (k + 1 < LOAD_FWD_STG)) begin
          o_load_young = 1'b1;
        end
      end
    end
  end

  assign o_wb_only = o_hit && (o_idx == SEL_W'(DEPTH - 1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift register of in-flight writers (EX..WB),
// registered per-source forward selects, load-use stall and ID WB bypass.
// Optional macro HAZARD_PERF_CNT_EN adds stall/forward performance counters;
// without it the counter ports are tied to zero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_STG = 2,
  parameter int SEL_W        = 2
) (
  input  logic                          cpu_clk,
  input  logic                          cpu_rst,
  input  logic                          hold,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  output logic                          stall_id,
  output logic [NUM_SRC-1:0]            id_wb_bypass,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   fwd_cnt
);

  hz_entry_t [DEPTH-1:0]      r_entry;
  logic [NUM_SRC*SEL_W-1:0]   r_fwd_sel;

  logic [SEL_W-1:0]           w_idx [NUM_SRC];
  logic [NUM_SRC-1:0]         w_hit;
  logic [NUM_SRC-1:0]         w_load_young;
  logic [NUM_SRC-1:0]         w_wb_only;
  logic                       w_issue;
  hz_entry_t                  w_new;
  logic [NUM_SRC*SEL_W-1:0]   w_fwd_next;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_match #(
      .DEPTH       (DEPTH),
      .LOAD_FWD_STG(LOAD_FWD_STG),
      .SEL_W       (SEL_W)
    ) u_match (
      .i_src       (id_src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .i_used      (id_src_used[g]),
      .i_entry     (r_entry),
      .o_idx       (w_idx[g]),
      .o_hit       (w_hit[g]),
      .o_load_young(w_load_young[g]),
      .o_wb_only   (w_wb_only[g])
    );
  end

  // A flushed instruction never stalls; the bubble it becomes is enough.
  assign stall_id     = id_valid && !flush && (|w_load_young);
  assign id_wb_bypass = w_wb_only;
  assign w_issue      = id_valid && !flush && !stall_id && !hold;
  assign fwd_sel      = r_fwd_sel;

  // Entry written into EX; a write to x0 is recorded as non-writing.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.rd      = id_rd;
    w_new.wen     = id_reg_write && (id_rd != '0);
    w_new.is_load = id_is_load;
  end

  // Matching stage k becomes stage k+1 once the reader reaches EX; a WB-only
  // producer is covered by the ID bypass instead of a forward.
  always_comb begin
    w_fwd_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_issue && w_hit[i] && !w_wb_only[i]) begin
        w_fwd_next[i*SEL_W +: SEL_W] = w_idx[i] + SEL_W'(1);
      end else begin
        w_fwd_next[i*SEL_W +: SEL_W] = SEL_W'(FWD_NONE);
      end
    end
  end

  // Advance the in-flight writer pipeline unless frozen.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_entry <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_entry[k] <= r_entry[k-1];
      end
      r_entry[0] <= w_issue ? w_new : hz_entry_t'('0);
    end
  end

  // Forward selects for the instruction entering EX.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_fwd_sel <= '0;
    end else if (!hold) begin
      r_fwd_sel <= w_fwd_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  // Count stall cycles and forwarding issues; both wrap naturally.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (!hold && stall_id) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_issue && (|w_fwd_next)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a DEPTH=3 instance for the main
// scenarios and a DEPTH=4/LOAD_FWD_STG=3 instance sharing the same inputs.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [14:0] id_src_addr = '0;
  logic [2:0]  id_src_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        id_is_load = 1'b0;

  logic        stall_id,  stall_id4;
  logic [2:0]  bypass,    bypass4;
  logic [5:0]  fwd_sel,   fwd_sel4;
  logic [31:0] stall_cnt, stall_cnt4;
  logic [31:0] fwd_cnt,   fwd_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cpu_clk = ~cpu_clk;

  hazard_scoreboard #(.NUM_SRC(3), .DEPTH(3), .LOAD_FWD_STG(2), .SEL_W(2)) u_dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .stall_id(stall_id), .id_wb_bypass(bypass), .fwd_sel(fwd_sel),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  hazard_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_FWD_STG(3), .SEL_W(2)) u_dut4 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .stall_id(stall_id4), .id_wb_bypass(bypass4), .fwd_sel(fwd_sel4),
    .stall_cnt(stall_cnt4), .fwd_cnt(fwd_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] used, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid     = v;
    id_src_addr  = {s2, s1, s0};
    id_src_used  = used;
    id_rd        = rd;
    id_reg_write = wr;
    id_is_load   = ld;
    #1;
  endtask

  task automatic chk_fwd(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, fwd_sel}, {26'd0, exp});
  endtask

  task automatic chk_id(input string tag, input logic exp_stall, input logic [2:0] exp_byp);
    chk({tag, "_stall"}, {31'd0, stall_id}, {31'd0, exp_stall});
    chk({tag, "_byp"}, {29'd0, bypass}, {29'd0, exp_byp});
  endtask

  task automatic chk_cnt(input string tag, input int exp_stall, input int exp_fwd);
    chk({tag, "_stall_cnt"}, stall_cnt, (PERF != 0) ? 32'(exp_stall) : 32'd0);
    chk({tag, "_fwd_cnt"}, fwd_cnt, (PERF != 0) ? 32'(exp_fwd) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    cpu_rst = 1'b1;
    cyc(); cyc();
    cpu_rst = 1'b0;
    chk_fwd("rst_fwd", 6'd0);
    chk_id("rst", 1'b0, 3'b000);
    chk_cnt("rst", 0, 0);
    chk("rst_fwd4", {26'd0, fwd_sel4}, 32'd0);
    chk("rst_stall_cnt4", stall_cnt4, 32'd0);

    // Back-to-back ALU: add x5 ; sub x8, x5, x6
    set_id(1, 5'd1, 5'd2, 5'd0, 3'b011, 5'd5, 1, 0);
    chk_id("add", 1'b0, 3'b000);
    cyc();
    chk_fwd("add_fwd", 6'd0);
    set_id(1, 5'd5, 5'd6, 5'd0, 3'b011, 5'd8, 1, 0);
    chk_id("b2b", 1'b0, 3'b000);
    cyc();
    chk_fwd("b2b_fwd", 6'b000001);
    chk_cnt("b2b", 0, 1);

    // Distance 2 and 3 on x7
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1, 0);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd10, 1, 0);
    cyc();
    set_id(1, 5'd0, 5'd7, 5'd0, 3'b010, 5'd0, 0, 0);
    chk_id("dist2", 1'b0, 3'b000);
    cyc();
    chk_fwd("dist2_fwd", 6'b001000);
    set_id(1, 5'd0, 5'd0, 5'd7, 3'b100, 5'd0, 0, 0);
    chk_id("dist3", 1'b0, 3'b100);
    cyc();
    chk_fwd("dist3_fwd", 6'd0);

    // Load-use: lw x3 ; add x11, x3
    set_id(1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd3, 1, 1);
    cyc();
    set_id(1, 5'd3, 5'd0, 5'd0, 3'b001, 5'd11, 1, 0);
    chk_id("lu", 1'b1, 3'b000);
    cyc();
    chk_fwd("lu_bubble_fwd", 6'd0);
    chk_id("lu_after", 1'b0, 3'b000);
    cyc();
    chk_fwd("lu_fwd", 6'b000010);
    chk_cnt("lu", 1, 3);

    // Priority: two writers to x9, reader of x9 on src0/src1
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1, 0);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1, 0);
    cyc();
    set_id(1, 5'd9, 5'd9, 5'd0, 3'b011, 5'd0, 0, 0);
    cyc();
    chk_fwd("prio_fwd", 6'b000101);

    // x0: load "to x0" then reader of x0
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1, 1);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b011, 5'd0, 0, 0);
    chk_id("x0", 1'b0, 3'b000);
    cyc();
    chk_fwd("x0_fwd", 6'd0);

    // Flush during load-use
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 1, 1);
    cyc();
    set_id(1, 5'd4, 5'd0, 5'd0, 3'b001, 5'd0, 0, 0);
    flush = 1'b1;
    #1;
    chk_id("flush", 1'b0, 3'b000);
    cyc();
    flush = 1'b0;
    chk_fwd("flush_fwd", 6'd0);
    chk_cnt("flush", 1, 4);

    // lw x12, 0(x4) forwards from stage 2
    set_id(1, 5'd4, 5'd0, 5'd0, 3'b001, 5'd12, 1, 1);
    chk_id("lw12", 1'b0, 3'b000);
    cyc();
    chk_fwd("lw12_fwd", 6'b000010);

    // Hold for 3 cycles with a pending load-use and a WB match
    set_id(1, 5'd12, 5'd4, 5'd0, 3'b011, 5'd15, 1, 0);
    hold = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_id("hold", 1'b1, 3'b010);
      cyc();
      chk_fwd("hold_fwd", 6'b000010);
    end
    chk_cnt("hold", 1, 5);
    hold = 1'b0;
    #1;
    cyc();
    chk_fwd("unhold_bubble_fwd", 6'd0);
    chk_cnt("unhold", 2, 5);
    chk_id("unhold", 1'b0, 3'b000);
    cyc();
    chk_fwd("unhold_fwd", 6'b000010);
    chk_cnt("unhold2", 2, 6);

    // Reset mid-stream with three valid writers
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd20, 1, 0);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd21, 1, 0);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd22, 1, 0);
    cyc();
    set_id(1, 5'd20, 5'd21, 5'd22, 3'b111, 5'd0, 0, 0);
    chk_id("full", 1'b0, 3'b001);
    cpu_rst = 1'b1;
    cyc();
    cpu_rst = 1'b0;
    #1;
    chk_id("mid_rst", 1'b0, 3'b000);
    chk_fwd("mid_rst_fwd", 6'd0);
    chk_cnt("mid_rst", 0, 0);
    cyc();
    chk_fwd("mid_rst_fwd2", 6'd0);

    // DEPTH=4, LOAD_FWD_STG=3: load two ahead still stalls
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd3, 1, 1);
    cyc();
    set_id(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd14, 1, 0);
    cyc();
    set_id(1, 5'd3, 5'd0, 5'd0, 3'b001, 5'd0, 0, 0);
    chk("d4_stall", {31'd0, stall_id4}, 32'd1);
    chk("d3_nostall", {31'd0, stall_id}, 32'd0);
    cyc();
    chk("d4_bubble_fwd", {26'd0, fwd_sel4}, 32'd0);
    chk_fwd("d3_fwd", 6'b000010);
    chk("d4_after_stall", {31'd0, stall_id4}, 32'd0);
    chk("d4_byp", {29'd0, bypass4}, 32'd0);
    cyc();
    chk("d4_fwd", {26'd0, fwd_sel4}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
